// File: rtl/cpu_pkg.sv
// Shared constants and types for the accumulator CPU control path.
package cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_JZ  = 4'h6;
  localparam logic [3:0] OP_LDI = 4'h7;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_FWAIT  = 3'd1,
    S_DECODE = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [1:0] ACC_SEL_ALU = 2'b00;
  localparam logic [1:0] ACC_SEL_MEM = 2'b01;
  localparam logic [1:0] ACC_SEL_IMM = 2'b10;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

  // NOP is the only opcode that raises no class flag.
  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic alu;
    logic jump;
    logic cond_jump;
    logic imm;
    logic halt;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Signals between the control sequencer and the datapath/memory it steers.
interface control_sequencer_if;
  logic [15:0] instr_in;
  logic        acc_zero;
  logic        mem_ready;
  logic        pc_inc;
  logic        pc_load;
  logic        ir_load;
  logic        mar_load;
  logic        mar_sel;
  logic        acc_load;
  logic [1:0]  acc_sel;
  logic [1:0]  alu_op;
  logic        mem_rd;
  logic        mem_wr;
  logic        halted;
  logic        illegal_op;
  logic        bus_error;

  modport master (
    input  instr_in, acc_zero, mem_ready,
    output pc_inc, pc_load, ir_load, mar_load, mar_sel, acc_load, acc_sel,
           alu_op, mem_rd, mem_wr, halted, illegal_op, bus_error
  );

  modport slave (
    output instr_in, acc_zero, mem_ready,
    input  pc_inc, pc_load, ir_load, mar_load, mar_sel, acc_load, acc_sel,
           alu_op, mem_rd, mem_wr, halted, illegal_op, bus_error
  );
endinterface

// File: rtl/opcode_decoder.sv
// Combinational opcode classifier feeding the control sequencer.
module opcode_decoder
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  output op_class_t  op_class
);

  always_comb begin
    op_class = '0;
    case (opcode)
      OP_NOP: ;
      OP_LDA: op_class.mem_read  = 1'b1;
      OP_ADD: op_class.alu       = 1'b1;
      OP_SUB: op_class.alu       = 1'b1;
      OP_STA: op_class.mem_write = 1'b1;
      OP_JMP: op_class.jump      = 1'b1;
      OP_JZ:  op_class.cond_jump = 1'b1;
      OP_LDI: op_class.imm       = 1'b1;
      OP_HLT: op_class.halt      = 1'b1;
      default: op_class.illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer for the 16-bit accumulator CPU: drives the
// datapath load strobes and the memory handshake with a wait-state timeout.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input logic                 clk,
  input logic                 rst_n,
  control_sequencer_if.master bus
);

  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);

  state_t     state;
  logic [7:0] wait_cnt;
  logic       bus_error_q;
  logic [3:0] opcode;
  op_class_t  op;
  logic       timeout;

  logic       pc_inc_c, pc_load_c, ir_load_c, mar_load_c, mar_sel_c;
  logic       acc_load_c, mem_rd_c, mem_wr_c, halted_c, illegal_op_c;
  logic [1:0] acc_sel_c, alu_op_c;

  assign opcode = bus.instr_in[15:12];

  opcode_decoder u_decoder (
    .opcode   (opcode),
    .op_class (op)
  );

  // Ready in the limit cycle still completes the access.
  assign timeout = !bus.mem_ready && (wait_cnt == WAIT_LIMIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_FETCH;
      wait_cnt    <= '0;
      bus_error_q <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          wait_cnt <= '0;
          state    <= S_FWAIT;
        end
        S_FWAIT: begin
          if (bus.mem_ready) begin
            state <= S_DECODE;
          end else if (timeout) begin
            bus_error_q <= 1'b1;
            state       <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_DECODE: begin
          wait_cnt <= '0;
          if (op.mem_read || op.mem_write || op.alu) begin
            state <= S_MEM;
          end else if (op.halt) begin
            state <= S_HALT;
          end else begin
            state <= S_FETCH;
          end
        end
        S_MEM: begin
          if (bus.mem_ready) begin
            state <= S_FETCH;
          end else if (timeout) begin
            bus_error_q <= 1'b1;
            state       <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    pc_inc_c     = 1'b0;
    pc_load_c    = 1'b0;
    ir_load_c    = 1'b0;
    mar_load_c   = 1'b0;
    mar_sel_c    = 1'b0;
    acc_load_c   = 1'b0;
    acc_sel_c    = ACC_SEL_ALU;
    alu_op_c     = ALU_PASS;
    mem_rd_c     = 1'b0;
    mem_wr_c     = 1'b0;
    halted_c     = 1'b0;
    illegal_op_c = 1'b0;
    case (state)
      S_FETCH: mar_load_c = 1'b1;
      S_FWAIT: begin
        mem_rd_c = 1'b1;
        if (bus.mem_ready) begin
          ir_load_c = 1'b1;
          pc_inc_c  = 1'b1;
        end
      end
      S_DECODE: begin
        if (op.imm) begin
          acc_load_c = 1'b1;
          acc_sel_c  = ACC_SEL_IMM;
        end
        if (op.jump)      pc_load_c = 1'b1;
        if (op.cond_jump) pc_load_c = bus.acc_zero;
        if (op.mem_read || op.mem_write || op.alu) begin
          mar_load_c = 1'b1;
          mar_sel_c  = 1'b1;
        end
        if (op.illegal)   illegal_op_c = 1'b1;
      end
      S_MEM: begin
        if (op.mem_write) mem_wr_c = 1'b1;
        else              mem_rd_c = 1'b1;
        if (bus.mem_ready && !op.mem_write) begin
          acc_load_c = 1'b1;
          if (op.alu) begin
            acc_sel_c = ACC_SEL_ALU;
            alu_op_c  = (opcode == OP_SUB) ? ALU_SUB : ALU_ADD;
          end else begin
            acc_sel_c = ACC_SEL_MEM;
          end
        end
      end
      S_HALT:  halted_c = 1'b1;
      default: ;
    endcase
  end

  // Reset silences every output immediately, dropping any pending request.
  assign bus.pc_inc     = rst_n & pc_inc_c;
  assign bus.pc_load    = rst_n & pc_load_c;
  assign bus.ir_load    = rst_n & ir_load_c;
  assign bus.mar_load   = rst_n & mar_load_c;
  assign bus.mar_sel    = rst_n & mar_sel_c;
  assign bus.acc_load   = rst_n & acc_load_c;
  assign bus.acc_sel    = rst_n ? acc_sel_c : 2'b00;
  assign bus.alu_op     = rst_n ? alu_op_c : 2'b00;
  assign bus.mem_rd     = rst_n & mem_rd_c;
  assign bus.mem_wr     = rst_n & mem_wr_c;
  assign bus.halted     = rst_n & halted_c;
  assign bus.illegal_op = rst_n & illegal_op_c;
  assign bus.bus_error  = rst_n & bus_error_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: an instruction-level model builds
// the expected per-cycle output trace, which is replayed against the DUT.
module tb_control_sequencer;

  localparam int TIMEOUT = 4;

  typedef struct packed {
    logic       pc_inc;
    logic       pc_load;
    logic       ir_load;
    logic       mar_load;
    logic       mar_sel;
    logic       acc_load;
    logic [1:0] acc_sel;
    logic [1:0] alu_op;
    logic       mem_rd;
    logic       mem_wr;
    logic       halted;
    logic       illegal_op;
    logic       bus_error;
  } outs_t;

  logic clk = 1'b0;
  logic rst_n;

  control_sequencer_if bus ();

  control_sequencer #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  outs_t exp_q[$];
  bit    rdy_q[$];
  bit    m_halted;
  bit    m_be;

  function automatic outs_t sample();
    outs_t o;
    o.pc_inc     = bus.pc_inc;
    o.pc_load    = bus.pc_load;
    o.ir_load    = bus.ir_load;
    o.mar_load   = bus.mar_load;
    o.mar_sel    = bus.mar_sel;
    o.acc_load   = bus.acc_load;
    o.acc_sel    = bus.acc_sel;
    o.alu_op     = bus.alu_op;
    o.mem_rd     = bus.mem_rd;
    o.mem_wr     = bus.mem_wr;
    o.halted     = bus.halted;
    o.illegal_op = bus.illegal_op;
    o.bus_error  = bus.bus_error;
    return o;
  endfunction

  task automatic push(input outs_t e, input bit rdy);
    exp_q.push_back(e);
    rdy_q.push_back(rdy);
  endtask

  task automatic push_halt(input int n);
    outs_t e;
    for (int i = 0; i < n; i++) begin
      e           = '0;
      e.halted    = 1'b1;
      e.bus_error = m_be;
      push(e, 1'($urandom));
    end
  endtask

  // One memory access: 'waits' not-ready cycles then ready, or a bus error
  // once TIMEOUT not-ready cycles have gone by.
  task automatic model_access(input int waits, input outs_t busy, input outs_t done, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < TIMEOUT; k++) begin
      if (k >= waits) begin
        push(done, 1'b1);
        ok = 1'b1;
        return;
      end
      push(busy, 1'b0);
    end
    m_be     = 1'b1;
    m_halted = 1'b1;
  endtask

  task automatic build_instr(input logic [15:0] instr, input bit az, input int fw, input int mw);
    outs_t      e, busy, done;
    bit         ok;
    logic [3:0] op;
    op = instr[15:12];
    if (m_halted) begin
      push_halt(3);
      return;
    end
    e = '0;
    e.mar_load = 1'b1;
    push(e, 1'($urandom));
    busy = '0;
    busy.mem_rd = 1'b1;
    done = busy;
    done.ir_load = 1'b1;
    done.pc_inc  = 1'b1;
    model_access(fw, busy, done, ok);
    if (!ok) begin
      push_halt(3);
      return;
    end
    e = '0;
    case (op)
      4'h0: ;
      4'h7: begin e.acc_load = 1'b1; e.acc_sel = 2'b10; end
      4'h5: e.pc_load = 1'b1;
      4'h6: e.pc_load = az;
      4'h1, 4'h2, 4'h3, 4'h4: begin e.mar_load = 1'b1; e.mar_sel = 1'b1; end
      4'hF: ;
      default: e.illegal_op = 1'b1;
    endcase
    push(e, 1'($urandom));
    if (op == 4'hF) begin
      m_halted = 1'b1;
      push_halt(3);
      return;
    end
    if (op inside {4'h1, 4'h2, 4'h3, 4'h4}) begin
      busy = '0;
      if (op == 4'h2) busy.mem_wr = 1'b1;
      else            busy.mem_rd = 1'b1;
      done = busy;
      case (op)
        4'h1: begin done.acc_load = 1'b1; done.acc_sel = 2'b01; end
        4'h3: begin done.acc_load = 1'b1; done.alu_op  = 2'b01; end
        4'h4: begin done.acc_load = 1'b1; done.alu_op  = 2'b10; end
        default: ;
      endcase
      model_access(mw, busy, done, ok);
      if (!ok) push_halt(3);
    end
  endtask

  task automatic play(input string name);
    outs_t e, got;
    bit    r;
    int    cyc = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      r = rdy_q.pop_front();
      bus.mem_ready = r;
      @(negedge clk);
      got = sample();
      checks++;
      if (got !== e) begin
        errors++;
        $display("[TB] FAIL %s cycle %0d: outputs got %h required %h", name, cyc, got, e);
      end
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_instr(input string name, input logic [15:0] instr, input bit az,
                           input int fw, input int mw);
    bus.instr_in = instr;
    bus.acc_zero = az;
    build_instr(instr, az, fw, mw);
    play(name);
  endtask

  task automatic apply_reset(input int n);
    outs_t got;
    rst_n = 1'b0;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      got = sample();
      checks++;
      if (got !== '0) begin
        errors++;
        $display("[TB] FAIL reset cycle %0d: outputs got %h required 0", i, got);
      end
      @(posedge clk);
      #1;
    end
    rst_n    = 1'b1;
    m_be     = 1'b0;
    m_halted = 1'b0;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    apply_reset(3);
  endtask

  task automatic test_nop();
    $display("[TB] test_nop");
    run_instr("nop", 16'h0000, 1'b0, 0, 0);
    run_instr("nop_again", 16'h0ABC, 1'b1, 0, 0);
  endtask

  task automatic test_add_waits();
    $display("[TB] test_add_waits");
    run_instr("add_wait2", 16'h3012, 1'b0, 0, 2);
    run_instr("sub", 16'h4034, 1'b0, 1, 0);
    run_instr("ldi", 16'h7FFF, 1'b0, 0, 0);
  endtask

  task automatic test_jz();
    $display("[TB] test_jz");
    run_instr("jz_taken", 16'h6100, 1'b1, 0, 0);
    run_instr("jz_not_taken", 16'h6100, 1'b0, 0, 0);
    run_instr("jmp", 16'h5123, 1'b0, 0, 0);
  endtask

  task automatic test_illegal_halt();
    $display("[TB] test_illegal_halt");
    run_instr("illegal", 16'h9000, 1'b0, 0, 0);
    run_instr("after_illegal", 16'h0000, 1'b0, 0, 0);
    bus.instr_in = 16'hF000;
    build_instr(16'hF000, 1'b0, 0, 0);
    push_halt(100);
    play("halt");
    apply_reset(1);
  endtask

  task automatic test_timeout();
    $display("[TB] test_timeout");
    run_instr("fetch_timeout", 16'h0000, 1'b0, TIMEOUT, 0);
    apply_reset(1);
    run_instr("ready_on_limit", 16'h0000, 1'b0, TIMEOUT - 1, 0);
    run_instr("lda_ready_on_limit", 16'h1200, 1'b0, 0, TIMEOUT - 1);
    run_instr("mem_timeout", 16'h1200, 1'b0, 0, TIMEOUT + 2);
    apply_reset(1);
  endtask

  task automatic test_reset_mid_wait();
    outs_t e;
    $display("[TB] test_reset_mid_wait");
    bus.instr_in = 16'h2055;
    bus.acc_zero = 1'b0;
    e = '0; e.mar_load = 1'b1;                     push(e, 1'b1);
    e = '0; e.mem_rd = 1'b1; e.ir_load = 1'b1;
    e.pc_inc = 1'b1;                               push(e, 1'b1);
    e = '0; e.mar_load = 1'b1; e.mar_sel = 1'b1;   push(e, 1'b0);
    e = '0; e.mem_wr = 1'b1;                       push(e, 1'b0);
    push(e, 1'b0);
    play("sta_pre_reset");
    apply_reset(1);
    run_instr("fetch_after_reset", 16'h0000, 1'b0, 0, 0);
  endtask

  task automatic test_random();
    int         op;
    logic [15:0] instr;
    $display("[TB] test_random");
    for (int n = 0; n < 40; n++) begin
      op    = int'($urandom_range(0, 14));
      instr = {4'(op), 12'($urandom)};
      run_instr("random", instr, 1'($urandom), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.mem_ready = 1'b0;
    bus.instr_in = 16'h0000;
    bus.acc_zero = 1'b0;
    m_be         = 1'b0;
    m_halted     = 1'b0;
    test_reset();
    test_nop();
    test_add_waits();
    test_jz();
    test_illegal_halt();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Multi-cycle fetch/decode/execute controller for the 16-bit accumulator CPU. Sits directly upstream of the datapath load registers (PC, IR, MAR, ACC): it generates their one-cycle load strobes and mux selects, and runs the memory read/write handshake with a wait-state timeout. It consumes the IR output and the ACC zero flag. It is the only source of register load enables in the core.

## Interface
- `MEM_TIMEOUT`, default 255: maximum cycles spent waiting for `mem_ready` in one access before a bus error (range 1..255).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `instr_in` in 16: IR output. Opcode is `[15:12]`; addr/imm is `[11:0]`.
- `acc_zero` in 1: ACC == 0.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_inc` out 1: PC <= PC+1.
- `pc_load` out 1: PC <= `instr_in[11:0]`.
- `ir_load` out 1: IR <= memory read data.
- `mar_load` out 1: MAR <= selected source.
- `mar_sel` out 1: 0 = PC, 1 = `instr_in[11:0]`.
- `acc_load` out 1: ACC <= selected source.
- `acc_sel` out 2: 00 = ALU, 01 = memory data, 10 = zero-extended imm12.
- `alu_op` out 2: 00 = pass, 01 = ADD, 10 = SUB.
- `mem_rd`, `mem_wr` out 1: memory request, held until `mem_ready`.
- `halted` out 1: core stopped.
- `illegal_op` out 1: one-cycle pulse on an undefined opcode.
- `bus_error` out 1: sticky; set on memory timeout.

## Operation
- Opcodes: 0 NOP, 1 LDA, 2 STA, 3 ADD, 4 SUB, 5 JMP, 6 JZ, 7 LDI, F HLT. Opcodes 8–E are illegal.
- Outputs are combinational from state, opcode, `mem_ready` and `acc_zero`. Any output not listed for a state is 0.
- S_FETCH: `mar_load`=1, `mar_sel`=0. Next state: S_FWAIT.
- S_FWAIT: `mem_rd`=1. When `mem_ready`=1: `ir_load`=1 and `pc_inc`=1, then go to S_DECODE. Otherwise stay.
- S_DECODE (acts on `instr_in`):
  - NOP: go to S_FETCH.
  - LDI: `acc_load`=1, `acc_sel`=10, then S_FETCH.
  - JMP: `pc_load`=1, then S_FETCH.
  - JZ: `pc_load` = `acc_zero`, then S_FETCH.
  - LDA/STA/ADD/SUB: `mar_load`=1, `mar_sel`=1, then S_MEM.
  - HLT: go to S_HALT.
  - Illegal: `illegal_op`=1, then S_FETCH.
- S_MEM:
  - LDA/ADD/SUB: `mem_rd`=1. On `mem_ready`: `acc_load`=1. LDA uses `acc_sel`=01; ADD/SUB use `acc_sel`=00 with `alu_op` 01/10. Then S_FETCH.
  - STA: `mem_wr`=1. On `mem_ready`, go to S_FETCH.
- S_HALT: `halted`=1. Terminal; only reset leaves it.
- Timeout:
  - An 8-bit wait counter clears on entry to S_FWAIT or S_MEM and increments each cycle `mem_ready`=0.
  - If `mem_ready` is still 0 after `MEM_TIMEOUT` wait cycles, set `bus_error`, drop the request, and go to S_HALT.
  - If `mem_ready` rises in the same cycle the limit is reached, the access completes normally; ready wins.
- Reset (`rst_n`=0 at an edge):
  - state <= S_FETCH; counter <= 0; `bus_error` <= 0.
  - While `rst_n`=0, every output is forced to 0.
  - Reset in any state, including mid-wait or S_HALT, abandons the current access. `mem_rd`/`mem_wr` drop in that same cycle.

## Timing
- All strobes last exactly one cycle and are sampled by the target registers at the next rising edge.
- `mem_rd`/`mem_wr` stay high from state entry through the `mem_ready` cycle inclusive, and are low the cycle after.
- Cycle counts with zero-wait memory (`mem_ready` already high on entry):
  - NOP, LDI, JMP, JZ: 3 cycles.
  - LDA, STA, ADD, SUB: 4 cycles.
  - Each wait cycle adds 1.
- The first fetch is S_FETCH in the first cycle after `rst_n` rises.
- `pc_inc` and `pc_load` are never high in the same cycle.
- `ir_load` is asserted only in S_FWAIT.

## Structure
- `cpu_pkg` holds:
  - opcode constants;
  - state encoding: S_FETCH, S_FWAIT, S_DECODE, S_MEM, S_HALT (3-bit);
  - `acc_sel` and `alu_op` codes.
- Sub-module `opcode_decoder`: combinational; maps `instr_in[15:12]` to one-hot class flags (mem_read, mem_write, alu, jump, cond_jump, imm, halt, illegal).
- The FSM and timeout counter live in `control_sequencer`.

## Test plan
- Reset, then NOP with `mem_ready` tied 1: `mar_load` in cycle 1; `mem_rd`+`ir_load`+`pc_inc` in cycle 2; back to S_FETCH in cycle 4; all outputs 0 while `rst_n`=0.
- `instr_in`=0x3012 (ADD 0x012) with 2 wait cycles in S_MEM: `mem_rd` high for 3 cycles; `acc_load`=1, `acc_sel`=00, `alu_op`=01 only in the third; total 6 cycles.
- `instr_in`=0x6100 (JZ): with `acc_zero`=1, `pc_load`=1 in S_DECODE; with `acc_zero`=0, no `pc_load`; both return to S_FETCH.
- `instr_in`=0x9000: `illegal_op` pulses for 1 cycle; execution continues with a fetch. Then `instr_in`=0xF000: `halted`=1 and stays high for 100 cycles of `mem_ready` toggling.
- `MEM_TIMEOUT`=4 and `mem_ready`=0 in S_FWAIT: `bus_error`=1 after 4 wait cycles, `mem_rd` drops, S_HALT. Repeat with `mem_ready`=1 on the limit cycle: normal completion, no error.
- `rst_n` low for 1 cycle mid-wait in S_MEM (STA): `mem_wr` drops in that cycle; `bus_error` clears; fetch restarts with `mar_load` the cycle after release.
